mdu_iter: RTL

Iterative multiply/divide unit holding the architectural HI/LO registers for the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over a start/busy/done handshake. Its `hi` and `lo` outputs feed two data inputs of the 32-bit writeback result multiplexer, where MFHI and MFLO select them. Control stalls the pipeline while `busy` is high.

---
 rtl/mdu_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU report as unsupported.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             unsupported
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [4:0]         cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic               neg_res;
   logic               op_mul;
   logic               op_div;
   logic               accept;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_if(input logic [2*WIDTH-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

   assign op_mul = ~op[2] & ~op[1];
`ifdef MDU_DIV_EN
   logic               is_div;
   logic               neg_rem;
   logic               dz;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_sub;

   assign op_div    = ~op[2] & op[1];
   // acc holds {partial remainder, dividend/quotient}; mcand holds the divisor
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_sub   = div_shift[WIDTH-1:0] - mcand;
`else
   assign op_div    = 1'b0;
`endif

   assign accept  = (state == IDLE) && start && (op_mul || op_div);
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

   // Iteration datapath, separate from the architectural HI/LO
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand   <= mag(b, op[0]);
         acc     <= {{WIDTH{1'b0}}, mag(a, op[0])};
         neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
         is_div  <= op_div;
         neg_rem <= op[0] & a[WIDTH-1];
         dz      <= (b == '0);
`endif
         if (op_mul) acc <= {{WIDTH{1'b0}}, mag(b, op[0])};
         if (op_mul) mcand <= mag(a, op[0]);
      end else if (state == RUN) begin
`ifdef MDU_DIV_EN
         if (is_div) begin
            if (div_shift >= {1'b0, mcand})
               acc <= {div_sub, acc[WIDTH-2:0], 1'b1};
            else
               acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end else
`endif
         acc <= {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      res_hi = neg_if(acc, neg_res) >> WIDTH;
      res_lo = neg_if(acc, neg_res);
`ifdef MDU_DIV_EN
      if (is_div) begin
         res_lo = dz ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
         res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
`endif
   end

   // Control FSM and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         unsupported <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         unsupported <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (op_mul || op_div) begin
                     state <= RUN;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end else if (op == 3'b100) begin
                     hi   <= a;
                     done <= 1'b1;
                  end else if (op == 3'b101) begin
                     lo   <= a;
                     done <= 1'b1;
                  end else begin
                     done        <= 1'b1;
                     unsupported <= 1'b1;
                  end
               end
            end
            RUN: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               hi    <= res_hi;
               lo    <= res_lo;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
